// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES state types plus the iterative InvSubBytes FSM encoding and sizing helpers.
package inv_sub_bytes_iter_pkg;

  // Existing cipher state types: byte k = 4*i + j lives at state[i][j].
  typedef logic [7:0] t_opaque_AESByte;
  typedef t_opaque_AESByte [3:0][3:0] t_opaque_AESState;

  localparam int unsigned NBYTES = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} t_iter_state;

  // Only power-of-two divisors of the state size give whole groups.
  function automatic bit legal_bpc(input int unsigned bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
  endfunction

  function automatic int unsigned ngroups(input int unsigned bpc);
    return (bpc == 0) ? NBYTES : NBYTES / bpc;
  endfunction

  // Counter keeps at least one bit so a single-group build still has a legal vector.
  function automatic int unsigned cnt_width(input int unsigned ng);
    return (ng > 1) ? $clog2(ng) : 1;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// FIPS-197 inverse S-box, purely combinational lookup.
module inv_sbox
  import inv_sub_bytes_iter_pkg::*;
(
  input  t_opaque_AESByte lhs,
  output t_opaque_AESByte o
);

  // Entry x sits at element 255-x because the first listed byte lands in the top slot.
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // 255 - lhs is simply the bitwise complement for an 8-bit index.
  assign o = INV_SBOX[~lhs];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes per cycle through shared
// inv_sbox instances, with valid/ready handshakes on both sides.
module inv_sub_bytes_iter
  import inv_sub_bytes_iter_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  t_opaque_AESState in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output t_opaque_AESState out_state
);

  localparam int unsigned NGROUPS = ngroups(BYTES_PER_CYCLE);
  localparam int unsigned CW      = cnt_width(NGROUPS);

  if (!legal_bpc(BYTES_PER_CYCLE)) begin : g_bad_bpc
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  t_iter_state      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  t_opaque_AESState work_q, work_d;
  t_opaque_AESState out_state_q, out_state_d;

  // Flat byte views of the work register: element k is byte k = 4*i + j.
  logic [15:0][7:0] work_bytes;
  logic [15:0][7:0] sub_bytes;

  logic [3:0]      byte_idx [BYTES_PER_CYCLE];
  t_opaque_AESByte sbox_in  [BYTES_PER_CYCLE];
  t_opaque_AESByte sbox_out [BYTES_PER_CYCLE];

  logic accept;
  logic last_group;

  assign work_bytes = work_q;
  assign last_group = (cnt_q == CW'(NGROUPS - 1));

  // Group g covers bytes g*BYTES_PER_CYCLE .. (g+1)*BYTES_PER_CYCLE-1; read and write-back
  // share the same index so each lane always owns one fixed byte of the current group.
  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_lane
    assign byte_idx[b] = 4'(32'(cnt_q) * BYTES_PER_CYCLE + 32'(b));
    assign sbox_in[b]  = work_bytes[byte_idx[b]];

    inv_sbox u_inv_sbox (
      .lhs (sbox_in[b]),
      .o   (sbox_out[b])
    );
  end

  // Merge the substituted group back into a copy of the work register.
  always_comb begin
    sub_bytes = work_bytes;
    for (int b = 0; b < int'(BYTES_PER_CYCLE); b++) begin
      sub_bytes[byte_idx[b]] = sbox_out[b];
    end
  end

  // in_ready never looks at in_valid, so upstream can gate on it without a loop.
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_state = out_state_q;

  // Next-state: capture on accept, one group per BUSY cycle, publish after the last group.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_state_d = out_state_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = sub_bytes;
        if (last_group) begin
          cnt_d       = '0;
          out_state_d = sub_bytes;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          // A waiting input is taken in the same cycle, avoiding an IDLE bubble.
          if (accept) begin
            work_d  = in_state;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and datapath registers; reset discards any partial state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_state_q <= out_state_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: scoreboard on the default build plus
// latency checks on the other legal widths and a standalone inv_sbox sweep.
module tb_inv_sub_bytes_iter;

  localparam logic [255:0][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam int ALT_BPC [4] = '{1, 2, 8, 16};
  localparam int ALT_LAT [4] = '{17, 9, 3, 2};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  logic         alt_in_valid;
  logic [127:0] alt_in_state;
  logic         alt_in_ready  [4];
  logic         alt_out_valid [4];
  logic [127:0] alt_out_state [4];

  logic [7:0]   sb_lhs;
  logic [7:0]   sb_o;

  logic [7:0]   inv_tbl [256];
  logic [127:0] sb [$];
  logic [127:0] exp_v;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  for (genvar g = 0; g < 4; g++) begin : g_alt
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(ALT_BPC[g])) u_alt (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (alt_in_valid),
      .in_ready  (alt_in_ready[g]),
      .in_state  (alt_in_state),
      .out_valid (alt_out_valid[g]),
      .out_ready (1'b1),
      .out_state (alt_out_state[g])
    );
  end

  inv_sbox u_sbox (
    .lhs (sb_lhs),
    .o   (sb_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Byte k of the written hex string (k=0 leftmost) goes to flat byte k.
  function automatic logic [127:0] from_hex(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = v[127-8*k -: 8];
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present s, wait for acceptance, queue the expected result; returns just after the
  // accepting edge with the cycle number of that edge.
  task automatic send(input logic [127:0] s, input logic [127:0] e, output int acc_cyc);
    int w;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_state = s;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      acc_cyc  = cyc;
      return;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Cycles counted with the accepting cycle as 1, until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Scoreboard: every completed output transfer is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_v = sb.pop_front();
        check("sb_out", out_state, exp_v);
      end
    end
  end

  initial begin
    int           lat;
    int           acc;
    int           prev_acc;
    bit           seen [4];
    logic [127:0] s;
    logic [127:0] c1_in;
    logic [127:0] c1_exp;

    for (int x = 0; x < 256; x++) inv_tbl[FWD_SBOX[8'(255 - x)]] = 8'(x);
    c1_in  = from_hex(128'h7a9f102789d5f50b2beffd9f3dca4ea7);
    c1_exp = from_hex(128'hbd6e7c3df2b5779e0b61216e8b10b689);

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_state     = '0;
    out_ready    = 1'b1;
    alt_in_valid = 1'b0;
    alt_in_state = '0;
    sb_lhs       = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_state", out_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // All 0x63 -> all 0x00, latency 5
    send({16{8'h63}}, {16{8'h00}}, acc);
    wait_valid(lat);
    check("lat_63", lat, 5);

    // C.1 vector on the default build
    send(c1_in, c1_exp, acc);
    wait_valid(lat);
    check("lat_c1", lat, 5);

    // C.1 vector on the other widths, launched together
    @(posedge clk); #1;
    alt_in_valid = 1'b1;
    alt_in_state = c1_in;
    @(negedge clk);
    for (int g = 0; g < 4; g++) check("alt_in_ready", alt_in_ready[g], 1);
    @(posedge clk); #1;
    alt_in_valid = 1'b0;
    alt_in_state = rand_state();
    for (int g = 0; g < 4; g++) seen[g] = 1'b0;
    lat = 0;
    repeat (20) begin
      lat++;
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (!seen[g] && alt_out_valid[g]) begin
          seen[g] = 1'b1;
          check($sformatf("alt_lat_bpc%0d", ALT_BPC[g]), lat, ALT_LAT[g]);
          check($sformatf("alt_c1_bpc%0d", ALT_BPC[g]), alt_out_state[g], c1_exp);
        end
      end
    end
    for (int g = 0; g < 4; g++) check($sformatf("alt_seen_bpc%0d", ALT_BPC[g]), seen[g], 1);

    // Backpressure: hold the result for 10 cycles, then hand off back-to-back
    @(posedge clk); #1;
    out_ready = 1'b0;
    send({16{8'h16}}, model({16{8'h16}}), acc);
    wait_valid(lat);
    check("bp_lat", lat, 5);
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_state", out_state, {16{8'hff}});
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = '0;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    sb.push_back({16{8'h52}});
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check("b2b_no_idle", in_ready, 0);
    wait_valid(lat);
    check("b2b_lat", lat, 5);

    // Reset in the third BUSY cycle
    s = rand_state();
    send(s, model(s), acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_state", out_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    send({16{8'hed}}, {16{8'h53}}, acc);
    wait_valid(lat);
    check("abort_lat", lat, 5);

    // in_state churns while BUSY
    s = rand_state();
    send(s, model(s), acc);
    repeat (6) begin
      @(posedge clk); #1;
      in_state = rand_state();
    end

    // Every byte value through the engine, back-to-back
    prev_acc = 0;
    for (int blk = 0; blk < 16; blk++) begin
      for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(16*blk + k);
      send(s, model(s), acc);
      if (blk > 0) check("throughput", acc - prev_acc, 5);
      prev_acc = acc;
    end

    // Standalone inverse S-box against the forward table
    for (int x = 0; x < 256; x++) begin
      sb_lhs = FWD_SBOX[8'(255 - x)];
      #1;
      check($sformatf("inv_sbox_%02h", x), sb_o, x);
    end

    lat = 0;
    while (sb.size() != 0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
- Iterative AES InvSubBytes engine for the decryption datapath.
- Inverse counterpart of the combinational forward SubBytes stage.
- Accepts one 4x4 AES state through a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per cycle through shared inv_sbox instances.
- Returns the substituted state through a valid/ready output handshake; trades latency for area against a 16-instance combinational version.

Parameters:
- BYTES_PER_CYCLE, 4, number of inv_sbox instances and bytes processed per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block can accept a state.
- in_state  in  t_opaque_AESState (4x4x8 = 128)  ciphertext-side state, indexed [i][j].
- out_valid  out  1  out_state is valid.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  t_opaque_AESState  inverse-substituted state, registered.

Behaviour:
- Byte index k = 4*i + j maps to state[i][j]. Iteration group g covers k = g*BYTES_PER_CYCLE .. (g+1)*BYTES_PER_CYCLE-1. NGROUPS = 16/BYTES_PER_CYCLE.
- FSM states:
  - IDLE: in_ready=1. in_valid&in_ready captures in_state into the work register, clears the group counter, and moves to BUSY.
  - BUSY: each cycle, the bytes of group g in the work register are replaced by inv_sbox(byte) and the counter increments. After the last group, the state moves to DONE and out_state is loaded with the completed work register.
  - DONE: out_valid=1 and out_state is held stable.
    - out_ready=1 completes the transfer.
    - If in_valid is also 1 in that cycle, in_ready=1, the new state is captured, and the FSM moves straight to BUSY (back-to-back operation, no IDLE bubble).
    - If in_valid=0, the FSM moves to IDLE.
    - out_ready=0 keeps DONE and holds out_state.
- in_ready = (IDLE) | (DONE & out_ready). in_ready is combinational from out_ready only, never from in_valid.
- Latency: out_valid rises exactly NGROUPS+1 cycles after the accepting edge (BYTES_PER_CYCLE=4 gives 5; =16 gives 2).
- Throughput: one state per NGROUPS+1 cycles with out_ready held high.
- Group counter width is max(1, clog2(NGROUPS)). With NGROUPS=1, BUSY lasts one cycle.
- in_state is sampled only at acceptance; changes while BUSY are ignored.
- Reset (any time, including mid-BUSY or DONE):
  - state=IDLE, out_valid=0, out_state=0, work register=0, counter=0.
  - A partially processed state is discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- inv_sbox is the pure FIPS-197 inverse S-box, combinational, 8b->8b. Examples: 0x63->0x00, 0x7C->0x01, 0x00->0x52, 0xED->0x53, 0x16->0xFF.

Decomposition:
- Shared package (existing CipherNoOpaques definitions): t_opaque_AESByte and t_opaque_AESState, unchanged.
- Package additions: the NGROUPS constant derivation and the FSM state enum {IDLE, BUSY, DONE}.
- Sub-module inv_sbox (lhs: AESByte in, o: AESByte out), instantiated BYTES_PER_CYCLE times. It sits alongside the existing forward sbox and is reusable by inv_cipher key-schedule-free paths.
- A byte mux selects group g from the work register; write-back uses the same index.

Test Plan:
- Reset then all-0x63 state, out_ready=1 -> all out_state bytes 0x00, out_valid high exactly 5 cycles after acceptance (BYTES_PER_CYCLE=4).
- FIPS-197 C.1 vector: bytes k=0..15 = 7a9f102789d5f50b2beffd9f3dca4ea7 -> out_state bytes bd6e7c3df2b5779e0b61216e8b10b689. Repeat for BYTES_PER_CYCLE = 1, 2, 8, 16 with latencies 17, 9, 3, 2.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_state stable, out_valid held, in_ready=0. out_ready=1 with in_valid=1 and a new state (all 0x00) -> same-cycle accept, next result all 0x52, no IDLE cycle.
- Reset asserted in the 3rd BUSY cycle -> out_valid=0 and out_state=0 immediately (async). Next accepted state all 0xED -> all 0x53, no corruption from the aborted operation.
- in_state changed every cycle while BUSY -> result reflects only the state captured at acceptance.
- Exhaustive inv_sbox: check inv_sbox(sbox(x))==x for x=0..255 against the forward sbox model.
